cva6_data_ram_arbiter: RTL and testbench



---
 rtl/cva6_mem_pkg.sv | 32 +++
 rtl/cva6_data_ram_arbiter_if.sv | 48 ++++
 rtl/cva6_rr_arb2.sv | 36 +++
 rtl/cva6_data_ram_arbiter.sv | 93 +++++++++
 tb/tb_cva6_data_ram_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cva6_mem_pkg.sv
// Shared memory-side definitions for CVA6 on-chip RAM arbiters: the data RAM
// geometry and the request/response records each arbiter port carries.
package cva6_mem_pkg;

  localparam logic [31:0] DATA_RAM_BASE   = 32'h1000_0000;
  localparam int          DATA_RAM_WORDS  = 1024;
  localparam int          DATA_RAM_ADDR_W = 12;
  localparam int          DATA_RAM_DATA_W = 32;

  // One requester's command as seen by an arbiter
  typedef struct packed {
    logic                       req;
    logic                       we;
    logic [3:0]                 be;
    logic [DATA_RAM_ADDR_W-1:0] addr;
    logic [DATA_RAM_DATA_W-1:0] wdata;
  } mem_req_t;

  // One requester's response as returned by an arbiter
  typedef struct packed {
    logic                       rvalid;
    logic                       err;
    logic [DATA_RAM_DATA_W-1:0] rdata;
  } mem_rsp_t;

  // True when a word address falls inside a RAM of the given word count
  function automatic logic addr_in_range(input logic [DATA_RAM_ADDR_W-1:0] addr,
                                         input int unsigned words);
    return ({{(32-DATA_RAM_ADDR_W){1'b0}}, addr} < words);
  endfunction

endpackage

// File: rtl/cva6_data_ram_arbiter_if.sv
// Bundle of the two requester ports plus the RAM-side port of the data RAM
// arbiter.
//
// Handshake: a requester raises p_req[k] and holds p_we/p_be/p_addr/p_wdata
// stable until p_gnt[k] is high; the request is accepted in the cycle where
// p_req[k] & p_gnt[k]. Exactly one cycle later p_rvalid[k] pulses for one
// cycle, with p_err[k] and p_rdata qualified by it. There is no backpressure
// on responses. The RAM side returns ram_rdata the cycle after ram_req.
interface cva6_data_ram_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic [1:0]        p_req;
  logic [1:0]        p_we;
  logic [3:0]        p_be0;
  logic [3:0]        p_be1;
  logic [ADDR_W-1:0] p_addr0;
  logic [ADDR_W-1:0] p_addr1;
  logic [DATA_W-1:0] p_wdata0;
  logic [DATA_W-1:0] p_wdata1;
  logic [1:0]        p_gnt;
  logic [1:0]        p_rvalid;
  logic [1:0]        p_err;
  logic [DATA_W-1:0] p_rdata0;
  logic [DATA_W-1:0] p_rdata1;
  logic              ram_req;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  p_req, p_we, p_be0, p_be1, p_addr0, p_addr1, p_wdata0, p_wdata1,
    input  ram_rdata,
    output p_gnt, p_rvalid, p_err, p_rdata0, p_rdata1,
    output ram_req, ram_we, ram_be, ram_addr, ram_wdata
  );

  // Requesters plus RAM
  modport master (
    output p_req, p_we, p_be0, p_be1, p_addr0, p_addr1, p_wdata0, p_wdata1,
    output ram_rdata,
    input  p_gnt, p_rvalid, p_err, p_rdata0, p_rdata1,
    input  ram_req, ram_we, ram_be, ram_addr, ram_wdata
  );
endinterface

// File: rtl/cva6_rr_arb2.sv
// Two-input round-robin grant with a last-grant register. Grant is
// combinational in the request cycle; on a conflict the port that was not
// granted most recently wins. After reset port 0 wins the first conflict.
module cva6_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output logic       o_last
);
  logic       r_last;
  logic [1:0] w_gnt;

  // Pick a winner; nothing is granted while reset is held
  always_comb begin
    w_gnt = 2'b00;
    if (!rst) begin
      case (i_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  // Remember the most recently granted port; hold when nothing is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_last <= 1'b1;
    else if (w_gnt[0]) r_last <= 1'b0;
    else if (w_gnt[1]) r_last <= 1'b1;
  end

  assign o_gnt  = w_gnt;
  assign o_last = r_last;
endmodule

// File: rtl/cva6_data_ram_arbiter.sv
// Shares the single-port CVA6 data RAM between the load/store unit (port 0)
// and the loader/debug port (port 1). Out-of-range word addresses are
// answered with an error response and never reach the RAM. Exactly one
// response can be in flight; it is returned the cycle after its grant.
module cva6_data_ram_arbiter
  import cva6_mem_pkg::*;
#(
  parameter int DATA_W      = DATA_RAM_DATA_W,
  parameter int ADDR_W      = DATA_RAM_ADDR_W,
  parameter int DEPTH_WORDS = DATA_RAM_WORDS
) (
  input  logic                    clk,
  input  logic                    rst,
  cva6_data_ram_arbiter_if.slave  bus,
  output logic                    o_dbg_last
);
  mem_req_t          w_port0;
  mem_req_t          w_port1;
  mem_req_t          w_win;
  mem_rsp_t          w_rsp0;
  mem_rsp_t          w_rsp1;
  logic [1:0]        w_gnt;
  logic              w_any;
  logic              w_sel;
  logic              w_in_range;
  logic              w_ram_go;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              r_rsp_valid;
  logic              r_rsp_port;
  logic              r_rsp_err;

  cva6_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req  (bus.p_req),
    .o_gnt  (w_gnt),
    .o_last (o_dbg_last)
  );

  // Collect each port's command into a record and select the winner
  always_comb begin
    w_port0 = '{req: bus.p_req[0], we: bus.p_we[0], be: bus.p_be0,
                addr: bus.p_addr0, wdata: bus.p_wdata0};
    w_port1 = '{req: bus.p_req[1], we: bus.p_we[1], be: bus.p_be1,
                addr: bus.p_addr1, wdata: bus.p_wdata1};
    w_any   = |w_gnt;
    w_sel   = w_gnt[1];
    w_win   = w_sel ? w_port1 : w_port0;
    w_addr  = w_win.addr;
    w_wdata = w_win.wdata;
    w_in_range = addr_in_range(w_win.addr, DEPTH_WORDS);
    w_ram_go   = w_any & w_win.req & w_in_range;
  end

  // Drive the RAM only for an in-range grant; all-zero otherwise
  always_comb begin
    bus.ram_req   = w_ram_go;
    bus.ram_we    = w_ram_go ? w_win.we : 1'b0;
    bus.ram_be    = w_ram_go ? w_win.be : 4'b0000;
    bus.ram_addr  = w_ram_go ? w_addr   : '0;
    bus.ram_wdata = w_ram_go ? w_wdata  : '0;
  end

  // Response tracker, reloaded every cycle from the current grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_port  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_any;
      r_rsp_port  <= w_sel;
      r_rsp_err   <= w_any & ~w_in_range;
    end
  end

  // Route the response to its port; the other port sees all zeros
  always_comb begin
    w_rsp0.rvalid = r_rsp_valid & ~r_rsp_port;
    w_rsp0.err    = w_rsp0.rvalid & r_rsp_err;
    w_rsp0.rdata  = (w_rsp0.rvalid & ~r_rsp_err) ? bus.ram_rdata : '0;
    w_rsp1.rvalid = r_rsp_valid & r_rsp_port;
    w_rsp1.err    = w_rsp1.rvalid & r_rsp_err;
    w_rsp1.rdata  = (w_rsp1.rvalid & ~r_rsp_err) ? bus.ram_rdata : '0;
  end

  assign bus.p_gnt    = w_gnt;
  assign bus.p_rvalid = {w_rsp1.rvalid, w_rsp0.rvalid};
  assign bus.p_err    = {w_rsp1.err, w_rsp0.err};
  assign bus.p_rdata0 = w_rsp0.rdata;
  assign bus.p_rdata1 = w_rsp1.rdata;
endmodule

// File: tb/tb_cva6_data_ram_arbiter.sv
// Bench for cva6_data_ram_arbiter: behavioural data RAM, table of request
// vectors with expected grants, response scoreboard fed by a reference
// memory image, hand sequences for reset, and a random single-port phase.
module tb_cva6_data_ram_arbiter;
  import cva6_mem_pkg::*;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int RW = 36;  // {valid, port, err, check_data, rdata}

  typedef struct {
    logic        r0, w0;
    logic [3:0]  b0;
    logic [11:0] a0;
    logic [31:0] d0;
    logic        r1, w1;
    logic [3:0]  b1;
    logic [11:0] a1;
    logic [31:0] d1;
    logic [1:0]  gnt;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic dbg_last;
  always #5 clk = ~clk;

  cva6_data_ram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  cva6_data_ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_dbg_last (dbg_last)
  );

  // Data RAM: one-cycle registered read returning the pre-write word
  logic [DW-1:0] ram_mem [1024];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= '0;
      bus.ram_rdata <= '0;
    end else if (bus.ram_req) begin
      bus.ram_rdata <= ram_mem[bus.ram_addr[9:0]];
      if (bus.ram_we)
        for (int b = 0; b < 4; b++)
          if (bus.ram_be[b]) ram_mem[bus.ram_addr[9:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  logic [31:0]   ref_mem [1024];
  int            n_vec = 0;
  int            n_bad = 0;
  vec_t          vecs [17];

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
  endtask

  // Compare the response currently on the ports against the oldest expectation
  task automatic check_rsp();
    logic [RW-1:0] e;
    logic          v, p, er, c;
    logic [31:0]   d;
    logic [1:0]    ev, ee;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL rsp_queue: got empty queue expected an entry at %0t", $time);
      return;
    end
    e = exp_q.pop_front();
    {v, p, er, c, d} = e;
    ev = v ? (p ? 2'b10 : 2'b01) : 2'b00;
    ee = er ? ev : 2'b00;
    chk("p_rvalid", bus.p_rvalid, ev);
    chk("p_err", bus.p_err, ee);
    if (!(ev[0] && !c)) chk("p_rdata0", bus.p_rdata0, ev[0] ? d : 32'h0);
    if (!(ev[1] && !c)) chk("p_rdata1", bus.p_rdata1, ev[1] ? d : 32'h0);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    bus.p_req    = {v.r1, v.r0};
    bus.p_we     = {v.w1, v.w0};
    bus.p_be0    = v.b0;
    bus.p_be1    = v.b1;
    bus.p_addr0  = v.a0;
    bus.p_addr1  = v.a1;
    bus.p_wdata0 = v.d0;
    bus.p_wdata1 = v.d1;
  endtask

  function automatic vec_t mk(input logic r0, w0, input logic [3:0] b0, input logic [11:0] a0,
                              input logic [31:0] d0, input logic r1, w1, input logic [3:0] b1,
                              input logic [11:0] a1, input logic [31:0] d1, input logic [1:0] g);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.b0 = b0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.b1 = b1; v.a1 = a1; v.d1 = d1;
    v.gnt = g;
    return v;
  endfunction

  // One cycle: drive, check last response and this grant, queue the next response
  task automatic step(input vec_t v);
    logic          sel, inr, we;
    logic [11:0]   a;
    logic [9:0]    ix;
    logic [3:0]    be;
    logic [31:0]   d;
    logic [RW-1:0] e;
    @(negedge clk);
    drive(v);
    #1;
    check_rsp();
    chk("p_gnt", bus.p_gnt, v.gnt);
    sel = v.gnt[1];
    a   = sel ? v.a1 : v.a0;
    we  = sel ? v.w1 : v.w0;
    be  = sel ? v.b1 : v.b0;
    d   = sel ? v.d1 : v.d0;
    ix  = a[9:0];
    inr = (v.gnt != 2'b00) && (a < 12'd1024);
    chk("ram_req", bus.ram_req, inr);
    chk("ram_addr", bus.ram_addr, inr ? a : 12'h0);
    chk("ram_we", bus.ram_we, inr & we);
    if (inr && we) chk("ram_wdata", bus.ram_wdata, d);
    if (v.gnt == 2'b00) e = '0;
    else if (!inr) e = {1'b1, sel, 1'b1, 1'b1, 32'h0};
    else if (we) begin
      e = {1'b1, sel, 1'b0, 1'b0, 32'h0};
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[ix][8*b +: 8] = d[8*b +: 8];
    end else e = {1'b1, sel, 1'b0, 1'b1, ref_mem[ix]};
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(mk(1, 0, 4'hF, 12'h5, 0, 1, 0, 4'hF, 12'h7, 0, 2'b00));
    exp_q.delete();
    clear_ref();
    #1;
    chk("rst_gnt", bus.p_gnt, 2'b00);
    chk("rst_ram_req", bus.ram_req, 1'b0);
    chk("rst_rvalid", bus.p_rvalid, 2'b00);
    chk("rst_err", bus.p_err, 2'b00);
    @(negedge clk);
    chk("rst_last", dbg_last, 1'b1);
    bus.p_req = 2'b00;
    rst = 1'b0;
    exp_q.push_back('0);
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));

    // Both ports requesting after reset: strict alternation starting at port 0
    for (int i = 0; i < 6; i++)
      vecs[i] = mk(1, 0, 4'hF, 12'h5, 0, 1, 0, 4'hF, 12'h7, 0, (i % 2 == 0) ? 2'b01 : 2'b10);
    vecs[6]  = mk(1, 1, 4'hF, 12'h5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b01);
    vecs[7]  = mk(1, 0, 4'hF, 12'h5, 0, 0, 0, 0, 0, 0, 2'b01);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    vecs[9]  = mk(1, 1, 4'hF, 12'h7, 32'h11223344, 0, 0, 0, 0, 0, 2'b01);
    vecs[10] = mk(0, 0, 0, 0, 0, 1, 1, 4'b0100, 12'h7, 32'hAA000000, 2'b10);
    vecs[11] = mk(1, 0, 4'hF, 12'h7, 0, 0, 0, 0, 0, 0, 2'b01);
    vecs[12] = mk(0, 0, 0, 0, 0, 1, 0, 4'hF, 12'h400, 0, 2'b10);
    vecs[13] = mk(0, 0, 0, 0, 0, 1, 0, 4'hF, 12'h3FF, 0, 2'b10);
    vecs[14] = mk(0, 0, 0, 0, 0, 1, 0, 4'hF, 12'hFFF, 0, 2'b10);
    vecs[15] = mk(1, 1, 4'hF, 12'h9, 32'h0000CAFE, 0, 0, 0, 0, 0, 2'b01);
    vecs[16] = mk(1, 0, 4'hF, 12'h9, 0, 0, 0, 0, 0, 0, 2'b01);

    do_reset();
    for (int i = 0; i < 17; i++) step(vecs[i]);

    // Reset asserted in the cycle after a grant discards its response
    step(mk(1, 0, 4'hF, 12'h5, 0, 0, 0, 0, 0, 0, 2'b01));
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.p_req = 2'b00;
    @(negedge clk);
    chk("midrst_rvalid", bus.p_rvalid, 2'b00);
    chk("midrst_last", dbg_last, 1'b1);
    exp_q.delete();
    clear_ref();
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('0);
    step(mk(1, 0, 4'hF, 12'h5, 0, 1, 0, 4'hF, 12'h7, 0, 2'b01));
    step(mk(0, 0, 0, 0, 0, 1, 0, 4'hF, 12'h7, 0, 2'b10));

    // Random single-requester traffic, including out-of-range addresses
    for (int i = 0; i < 60; i++) begin
      int unsigned   who;
      logic          w;
      logic [3:0]    b;
      logic [11:0]   a;
      logic [31:0]   d;
      who = $urandom_range(0, 2);
      w   = 1'($urandom_range(0, 1));
      b   = 4'($urandom_range(0, 15));
      a   = 12'($urandom_range(0, 1100));
      if (i % 8 == 0) a = 12'($urandom_range(1024, 4095));
      d   = $urandom;
      if (who == 0)      step(mk(1, w, b, a, d, 0, 0, 0, 0, 0, 2'b01));
      else if (who == 1) step(mk(0, 0, 0, 0, 0, 1, w, b, a, d, 2'b10));
      else               step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    end

    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
